// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: states, opcodes,
// ALU operations, register-file write sources and fault codes.
package mcpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_MOV   = 4'd4;
    localparam logic [3:0] OP_SHORT = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_BNZ   = 4'd8;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_IMM = 2'd1;
    localparam logic [1:0] WSRC_MEM = 2'd2;
    localparam logic [1:0] WSRC_RA  = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    function automatic logic is_legal(input logic [3:0] opcode);
        return opcode <= OP_BNZ;
    endfunction

    function automatic logic is_mem_op(input logic [3:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/mcpu_ctrl_timer.sv
// Counts consecutive unacknowledged memory-request cycles; expired fires on
// the MEM_TIMEOUT-th such cycle so the controller can halt on the next edge.
module mcpu_ctrl_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM sequencing, sticky
// fault reporting, memory timeout watchdog and a retired-instruction counter.
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        rf_src_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic [1:0]  rf_wsrc,
    output logic [1:0]  alu_op,
    output logic [1:0]  fault,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    state_t      cur_state;
    state_t      next_state;
    logic [3:0]  opcode;
    logic [1:0]  fault_set;
    logic        retire;
    logic        expired;
    logic        wait_en;
    logic        mem_req_raw;
    logic        mem_we_raw;
    logic        ir_we_raw;
    logic        pc_we_raw;
    logic        rf_we_raw;

    assign opcode = instr[15:12];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_FETCH;
            fault     <= FAULT_NONE;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (fault == FAULT_NONE && fault_set != FAULT_NONE) begin
                fault <= fault_set;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

    always_comb begin
        next_state  = cur_state;
        fault_set   = FAULT_NONE;
        retire      = 1'b0;
        mem_req_raw = 1'b0;
        mem_we_raw  = 1'b0;
        ir_we_raw   = 1'b0;
        pc_we_raw   = 1'b0;
        rf_we_raw   = 1'b0;
        addr_sel    = 1'b0;
        pc_sel      = 1'b0;
        rf_wsrc     = WSRC_ALU;
        alu_op      = ALU_ADD;

        case (cur_state)
            ST_FETCH: begin
                mem_req_raw = 1'b1;
                if (mem_ack) begin
                    ir_we_raw  = 1'b1;
                    next_state = ST_DECODE;
                end else if (expired) begin
                    next_state = ST_HALT;
                    fault_set  = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_mem_op(opcode)) begin
                    next_state = ST_MEM;
                end else if (is_legal(opcode)) begin
                    next_state = ST_EXEC;
                end else begin
                    next_state = ST_HALT;
                    fault_set  = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                pc_we_raw  = 1'b1;
                retire     = 1'b1;
                next_state = ST_FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_OR, OP_XOR: begin
                        rf_we_raw = 1'b1;
                        rf_wsrc   = WSRC_ALU;
                        alu_op    = opcode[1:0];
                    end
                    OP_MOV: begin
                        rf_we_raw = 1'b1;
                        rf_wsrc   = WSRC_RA;
                    end
                    OP_SHORT: begin
                        rf_we_raw = 1'b1;
                        rf_wsrc   = WSRC_IMM;
                    end
                    OP_BNZ: begin
                        pc_sel = ~rf_src_zero;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req_raw = 1'b1;
                addr_sel    = 1'b1;
                mem_we_raw  = (opcode == OP_STORE);
                if (mem_ack) begin
                    pc_we_raw  = 1'b1;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                    if (opcode == OP_LOAD) begin
                        rf_we_raw = 1'b1;
                        rf_wsrc   = WSRC_MEM;
                    end
                end else if (expired) begin
                    next_state = ST_HALT;
                    fault_set  = FAULT_TIMEOUT;
                end
            end
            ST_HALT: ;
            default: next_state = ST_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing reaches the RAM or register file while it is held.
    assign mem_req = mem_req_raw & ~reset;
    assign mem_we  = mem_we_raw  & ~reset;
    assign ir_we   = ir_we_raw   & ~reset;
    assign pc_we   = pc_we_raw   & ~reset;
    assign rf_we   = rf_we_raw   & ~reset;
    assign state   = cur_state;

    assign wait_en = mem_req_raw & ~mem_ack;

    mcpu_ctrl_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~wait_en),
        .enable  (wait_en),
        .expired (expired)
    );

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed self-checking bench for mcpu_ctrl: instruction sequencing,
// memory wait/timeout, illegal opcode halt and asynchronous reset.
module tb_mcpu_ctrl;
    import mcpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        rf_src_zero;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        rf_we;
    logic [1:0]  rf_wsrc;
    logic [1:0]  alu_op;
    logic [1:0]  fault;
    logic [2:0]  state;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    mcpu_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .rf_src_zero (rf_src_zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .rf_we       (rf_we),
        .rf_wsrc     (rf_wsrc),
        .alu_op      (alu_op),
        .fault       (fault),
        .state       (state),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] i, input logic ack, input logic zero);
        instr       = i;
        mem_ack     = ack;
        rf_src_zero = zero;
        #1;
    endtask

    // FETCH with immediate ack then DECODE; leaves the DUT at the start of EXEC or MEM.
    task automatic fetchDecode(input logic [15:0] i, input logic zero);
        applyStimulus(i, 1'b1, zero);
        checkOutput("fetch_state", 16'(state), 16'(ST_FETCH));
        checkOutput("fetch_ir_we", 16'(ir_we), 16'd1);
        stepCycle();
        applyStimulus(i, 1'b1, zero);
        checkOutput("decode_state", 16'(state), 16'(ST_DECODE));
        checkOutput("decode_strobes", 16'({mem_req, ir_we, pc_we, rf_we}), 16'd0);
        stepCycle();
    endtask

    initial begin
        int req_cycles;
        reset       = 1'b1;
        instr       = 16'h0000;
        mem_ack     = 1'b0;
        rf_src_zero = 1'b0;
        #2;
        checkOutput("rst_state", 16'(state), 16'(ST_FETCH));
        checkOutput("rst_mem_req", 16'(mem_req), 16'd0);
        checkOutput("rst_retired", retired, 16'd0);
        checkOutput("rst_fault", 16'(fault), 16'd0);
        stepCycle();
        reset = 1'b0;

        // SHORT_TO_REG r4 <- 0x0A
        fetchDecode(16'h540A, 1'b0);
        applyStimulus(16'h540A, 1'b1, 1'b0);
        checkOutput("short_state", 16'(state), 16'(ST_EXEC));
        checkOutput("short_rf_we", 16'(rf_we), 16'd1);
        checkOutput("short_wsrc", 16'(rf_wsrc), 16'(WSRC_IMM));
        checkOutput("short_retired_pre", retired, 16'd0);
        stepCycle();
        checkOutput("short_retired", retired, 16'd1);

        // AND r6 <- r4 & r5
        fetchDecode(16'h1645, 1'b0);
        applyStimulus(16'h1645, 1'b0, 1'b0);
        checkOutput("and_alu_op", 16'(alu_op), 16'(ALU_AND));
        checkOutput("and_wsrc", 16'(rf_wsrc), 16'(WSRC_ALU));
        checkOutput("and_pc", 16'({pc_we, pc_sel}), 16'b10);
        checkOutput("and_rf_we", 16'(rf_we), 16'd1);
        stepCycle();

        // MOV rA <- rB
        fetchDecode(16'h4AB0, 1'b0);
        applyStimulus(16'h4AB0, 1'b0, 1'b0);
        checkOutput("mov_wsrc", 16'(rf_wsrc), 16'(WSRC_RA));
        stepCycle();
        checkOutput("mov_retired", retired, 16'd3);

        // BNZ taken and not taken
        fetchDecode(16'h8C09, 1'b0);
        applyStimulus(16'h8C09, 1'b0, 1'b0);
        checkOutput("bnz_taken_pc", 16'({pc_we, pc_sel}), 16'b11);
        checkOutput("bnz_taken_rf_we", 16'(rf_we), 16'd0);
        stepCycle();
        fetchDecode(16'h8C09, 1'b1);
        applyStimulus(16'h8C09, 1'b0, 1'b1);
        checkOutput("bnz_fall_pc", 16'({pc_we, pc_sel}), 16'b10);
        checkOutput("bnz_fall_rf_we", 16'(rf_we), 16'd0);
        stepCycle();
        checkOutput("bnz_retired", retired, 16'd5);

        // STORE with ack delayed four cycles
        fetchDecode(16'h76FF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(16'h76FF, 1'b0, 1'b0);
            checkOutput("store_wait_bus", 16'({mem_req, mem_we, addr_sel}), 16'b111);
            checkOutput("store_wait_we", 16'({pc_we, rf_we}), 16'b00);
            stepCycle();
        end
        applyStimulus(16'h76FF, 1'b1, 1'b0);
        checkOutput("store_ack_bus", 16'({mem_req, mem_we, addr_sel}), 16'b111);
        checkOutput("store_ack_we", 16'({pc_we, rf_we}), 16'b10);
        stepCycle();
        applyStimulus(16'h76FF, 1'b0, 1'b0);
        checkOutput("store_done_state", 16'(state), 16'(ST_FETCH));
        checkOutput("store_retired", retired, 16'd6);

        // LOAD with immediate ack
        fetchDecode(16'h6312, 1'b0);
        applyStimulus(16'h6312, 1'b1, 1'b0);
        checkOutput("load_state", 16'(state), 16'(ST_MEM));
        checkOutput("load_we", 16'({mem_we, rf_we, pc_we}), 16'b011);
        checkOutput("load_wsrc", 16'(rf_wsrc), 16'(WSRC_MEM));
        stepCycle();
        checkOutput("load_retired", retired, 16'd7);

        // Illegal opcode halts with sticky fault
        fetchDecode(16'hF000, 1'b0);
        applyStimulus(16'hF000, 1'b1, 1'b0);
        checkOutput("illegal_state", 16'(state), 16'(ST_HALT));
        checkOutput("illegal_fault", 16'(fault), 16'(FAULT_ILLEGAL));
        checkOutput("halt_strobes", 16'({mem_req, mem_we, ir_we, pc_we, rf_we}), 16'd0);
        stepCycle();
        stepCycle();
        checkOutput("halt_retired", retired, 16'd7);
        checkOutput("halt_hold", 16'(state), 16'(ST_HALT));

        // Fetch timeout
        reset = 1'b1;
        #1;
        checkOutput("rst2_state", 16'(state), 16'(ST_FETCH));
        checkOutput("rst2_fault", 16'(fault), 16'd0);
        checkOutput("rst2_retired", retired, 16'd0);
        stepCycle();
        reset = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        req_cycles = 0;
        for (int n = 0; n < 40 && state != 3'(ST_HALT); n++) begin
            if (mem_req) req_cycles++;
            stepCycle();
        end
        checkOutput("timeout_cycles", 16'(req_cycles), 16'd15);
        checkOutput("timeout_fault", 16'(fault), 16'(FAULT_TIMEOUT));
        checkOutput("timeout_req_low", 16'(mem_req), 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        stepCycle();
        checkOutput("timeout_hold", 16'({state, mem_req, ir_we}), 16'({ST_HALT, 2'b00}));

        // Reset asserted mid-MEM
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        fetchDecode(16'h2123, 1'b0);
        applyStimulus(16'h2123, 1'b0, 1'b0);
        checkOutput("or_alu_op", 16'(alu_op), 16'(ALU_OR));
        stepCycle();
        fetchDecode(16'h6100, 1'b0);
        applyStimulus(16'h6100, 1'b0, 1'b0);
        stepCycle();
        checkOutput("midmem_req", 16'({state, mem_req, addr_sel}), 16'({ST_MEM, 2'b11}));
        checkOutput("midmem_retired", retired, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_strobes", 16'({mem_req, mem_we, ir_we, pc_we, rf_we}), 16'd0);
        checkOutput("midrst_state", 16'(state), 16'(ST_FETCH));
        checkOutput("midrst_retired", retired, 16'd0);
        stepCycle();
        checkOutput("midrst_hold_req", 16'(mem_req), 16'd0);
        reset = 1'b0;
        applyStimulus(16'h0000, 1'b1, 1'b0);
        checkOutput("restart_fetch", 16'({state, mem_req, ir_we, addr_sel}), 16'({ST_FETCH, 3'b110}));
        stepCycle();
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("restart_decode", 16'(state), 16'(ST_DECODE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a memory request may wait for mem_ack.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr  input  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb, [7:0] imm8.
REQ-005 SHALL have port rf_src_zero  input  1  register selected by rd equals zero (BNZ test).
REQ-006 SHALL have port mem_ack  input  1  RAM completes the current request this cycle.
REQ-007 SHALL have port mem_req  output  1  RAM access request.
REQ-008 SHALL have port mem_we  output  1  RAM write (store).
REQ-009 SHALL have port addr_sel  output  1  RAM address source: 0=PC, 1=imm8.
REQ-010 SHALL have port ir_we  output  1  instruction register load.
REQ-011 SHALL have port pc_we  output  1  PC update.
REQ-012 SHALL have port pc_sel  output  1  next PC: 0=PC+1, 1=imm8.
REQ-013 SHALL have port rf_we  output  1  register file write to rd.
REQ-014 SHALL have port rf_wsrc  output  2  write data: 0=ALU, 1=imm8 zero-extended, 2=RAM data, 3=R[ra].
REQ-015 SHALL have port alu_op  output  2  0=ADD, 1=AND, 2=OR, 3=XOR.
REQ-016 SHALL have port fault  output  2  0=none, 1=illegal opcode, 2=memory timeout; sticky.
REQ-017 SHALL have port state  output  3  current FSM state encoding.
REQ-018 SHALL have port retired  output  16  count of completed instructions.

Function
REQ-019 SHALL decode opcodes 0 ADD, 1 AND, 2 OR, 3 XOR, 4 MOV, 5 SHORT_TO_REG, 6 LOAD_FROM_MEM, 7 STORE_TO_MEM, 8 BNZ; 9-15 illegal.
REQ-020 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
REQ-021 FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ack assert ir_we that cycle and go to DECODE.
REQ-022 DECODE: one cycle, no side effects; opcodes 0-5 and 8 -> EXEC, 6-7 -> MEM, illegal -> HALT with fault=1.
REQ-023 EXEC ALU ops (0-3): rf_we=1, rf_wsrc=0, alu_op=opcode[1:0]; MOV: rf_wsrc=3; SHORT_TO_REG: rf_wsrc=1.
REQ-024 EXEC BNZ: rf_we=0, pc_we=1, pc_sel=~rf_src_zero.
REQ-025 EXEC non-branch: pc_we=1, pc_sel=0; EXEC always -> FETCH next cycle.
REQ-026 MEM: mem_req=1, addr_sel=1, mem_we=(opcode==7); on mem_ack: load asserts rf_we with rf_wsrc=2, pc_we=1, pc_sel=0, -> FETCH.
REQ-027 All control outputs SHALL be Moore/Mealy-combinational from state, instr and mem_ack; rf_we, pc_we, ir_we, mem_we SHALL be 0 in any state not listed as asserting them.
REQ-028 Minimum instruction latency SHALL be 3 cycles (FETCH with immediate ack, DECODE, EXEC/MEM with immediate ack).
REQ-029 A wait counter SHALL count consecutive mem_req cycles without mem_ack; reaching MEM_TIMEOUT SHALL enter HALT with fault=2, deasserting mem_req the next cycle.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 retired SHALL increment by 1 on each cycle leaving EXEC or completing MEM; wraps 0xFFFF -> 0x0000.
REQ-032 HALT SHALL hold all strobes low and retired frozen until reset.

Reset
REQ-033 reset SHALL immediately force state=FETCH, fault=0, retired=0, wait counter=0, abandoning any in-flight access.
REQ-034 While reset is high, all strobes (mem_req, mem_we, ir_we, pc_we, rf_we) SHALL be 0; first fetch request occurs the cycle after deassertion.

Structure
REQ-035 Opcode constants, state encodings, alu_op and rf_wsrc codes SHALL live in shared package mcpu_pkg, used by the core and benches.
REQ-036 The wait/timeout counter SHALL be a sub-module mcpu_ctrl_timer (clear, enable, expired).

Verification
REQ-037 Reset, then instr=5_4_0A with immediate acks -> FETCH,DECODE,EXEC; rf_we=1, rf_wsrc=1 in EXEC; retired=1 after 3 cycles.
REQ-038 instr=1_6_4_5 (AND) -> EXEC shows alu_op=1, rf_wsrc=0, pc_sel=0; instr=4_A_B_0 (MOV) -> rf_wsrc=3.
REQ-039 instr=8_C_09 with rf_src_zero=0 -> pc_we=1, pc_sel=1; with rf_src_zero=1 -> pc_sel=0, rf_we=0.
REQ-040 instr=7_6_FF, mem_ack delayed 4 cycles -> mem_req/mem_we/addr_sel high 5 cycles, pc_we on ack cycle only, rf_we never.
REQ-041 mem_ack never returned in FETCH -> HALT, fault=2 after 15 request cycles, mem_req low thereafter; instr=F000 -> fault=1.
REQ-042 reset asserted mid-MEM with mem_req high -> outputs drop same cycle, retired=0, fetch restarts after deassertion.
